// File: rtl/ram512_arbiter_pkg.sv
// Shared memory-subsystem definitions: RAM geometry and arbiter state encoding.
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/ram512_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the ram512 ports.
// master: requester/RAM side, slave: the arbiter.
interface ram512_arbiter_if;
    import mem_pkg::*;

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;
    logic              busy;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_address, ram_in, ram_load, busy,
        output ram_out
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, ack1, rdata1,
        output ram_address, ram_in, ram_load, busy,
        input  ram_out
    );

endinterface

// File: rtl/ram512_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, on contention the port
// that was not granted last wins.
module rr_arbiter2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    // Combinational winner selection
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = 1'b0;
        if (i_req0 && i_req1)
            o_grant = ~i_last_grant;
        else if (i_req1)
            o_grant = 1'b1;
    end

endmodule

// File: rtl/ram512_arbiter.sv
// Round-robin arbiter sharing one ram512 between two req/ack requesters.
// Each access runs IDLE -> ACCESS -> DONE; the command is registered at the
// grant so requester inputs may change freely once granted.
// Optional: define RAM512_ARB_STATS_EN to add saturating per-port grant counters.
module ram512_arbiter
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    ram512_arbiter_if.slave     bus
`ifdef RAM512_ARB_STATS_EN
    ,
    output logic [15:0]         o_grant_cnt0,
    output logic [15:0]         o_grant_cnt1
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic              w_grant;
    logic              w_gnt_vld;
    logic              w_gnt_idx;

    logic              r_last_grant;
    logic              r_cmd_port;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;

    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    rr_arbiter2 u_rr (
        .i_req0       (bus.req0),
        .i_req1       (bus.req1),
        .i_last_grant (r_last_grant),
        .o_valid      (w_gnt_vld),
        .o_grant      (w_gnt_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; arbitration only takes effect in IDLE
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_grant = 1'b1;
                    w_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Latch the winner's command and remember it for round-robin fairness
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_cmd_port   <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_gnt_idx;
            r_cmd_port   <= w_gnt_idx;
            r_cmd_we     <= w_gnt_idx ? bus.we1    : bus.we0;
            r_cmd_addr   <= w_gnt_idx ? bus.addr1  : bus.addr0;
            r_cmd_wdata  <= w_gnt_idx ? bus.wdata1 : bus.wdata0;
        end
    end

    // Capture RAM output in ACCESS (pre-write value on writes) and pulse ack in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (r_state == ST_ACCESS) begin
                if (r_cmd_port) begin
                    r_ack1   <= 1'b1;
                    r_rdata1 <= bus.ram_out;
                end else begin
                    r_ack0   <= 1'b1;
                    r_rdata0 <= bus.ram_out;
                end
            end
        end
    end

    // Load is gated with reset so an abandoned ACCESS never writes
    assign bus.ram_address = r_cmd_addr;
    assign bus.ram_in      = r_cmd_wdata;
    assign bus.ram_load    = (r_state == ST_ACCESS) & r_cmd_we & ~reset;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;

`ifdef RAM512_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Saturating grant counters, bumped on entry to ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_grant) begin
            if (!w_gnt_idx && r_cnt0 != 16'hFFFF)
                r_cnt0 <= r_cnt0 + 16'd1;
            if (w_gnt_idx && r_cnt1 != 16'hFFFF)
                r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign o_grant_cnt0 = r_cnt0;
    assign o_grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_ram512_arbiter.sv
// Bench for ram512_arbiter: behavioural ram512 plus a reference memory and
// round-robin expectation model; randomized traffic on top of directed cases.
module tb_ram512_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic preload_en;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram512_arbiter_if bus ();

`ifdef RAM512_ARB_STATS_EN
    logic [15:0] gc0, gc1;
`endif

    ram512_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef RAM512_ARB_STATS_EN
        ,
        .o_grant_cnt0 (gc0),
        .o_grant_cnt1 (gc1)
`endif
    );

    // Behavioural ram512: combinational read, write at the clock edge
    logic [15:0] init_ram [0:511];
    logic [15:0] ram      [0:511];
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_ram[i];
        end else if (bus.ram_load) begin
            ram[bus.ram_address] <= bus.ram_in;
        end
    end
    assign bus.ram_out = ram[bus.ram_address];

    // Protocol monitors
    int both_ack_cnt = 0;
    int stray_load_cnt = 0;
    int ack_q[$];
    always @(negedge clk) begin
        if (bus.ack0 && bus.ack1) both_ack_cnt++;
        if (bus.ram_load && !bus.busy) stray_load_cnt++;
        if (bus.ack0) ack_q.push_back(0);
        if (bus.ack1) ack_q.push_back(1);
    end

    // Reference model: flat memory image plus the last served port
    logic [15:0] mem_ref [0:511];
    int last_served;

    function automatic logic [15:0] ref_access(input bit we, input logic [8:0] a,
                                               input logic [15:0] d);
        logic [15:0] old;
        old = mem_ref[a];
        if (we) mem_ref[a] = d;
        return old;
    endfunction

    // Drive one request on port p, wait for its ack, release req afterwards
    task automatic txn(input int p, input bit we, input logic [8:0] a,
                       input logic [15:0] d, output logic [15:0] rd,
                       output int ack_cyc);
        int n;
        bit got;
        n = 0;
        got = 0;
        rd = 'x;
        ack_cyc = -1;
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (p == 0 && bus.ack0) begin
                got = 1; rd = bus.rdata0; ack_cyc = cyc;
            end else if (p == 1 && bus.ack1) begin
                got = 1; rd = bus.rdata1; ack_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        if (p == 0) begin
            bus.req0 = 1'b0; bus.we0 = 1'($urandom);
            bus.addr0 = 9'($urandom); bus.wdata0 = 16'($urandom);
        end else begin
            bus.req1 = 1'b0; bus.we1 = 1'($urandom);
            bus.addr1 = 9'($urandom); bus.wdata1 = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        last_served = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        preload_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload_en = 1'b0;
        n_chk++; if (bus.ram_load !== 1'b0) $display("FAIL rst_ram_load got=%b exp=0", bus.ram_load); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.ack0 !== 1'b0) $display("FAIL rst_ack0 got=%b exp=0", bus.ack0); else n_pass++;
        n_chk++; if (bus.ack1 !== 1'b0) $display("FAIL rst_ack1 got=%b exp=0", bus.ack1); else n_pass++;
        n_chk++; if (bus.rdata0 !== 16'h0) $display("FAIL rst_rdata0 got=%h exp=0", bus.rdata0); else n_pass++;
        n_chk++; if (bus.rdata1 !== 16'h0) $display("FAIL rst_rdata1 got=%h exp=0", bus.rdata1); else n_pass++;
        n_chk++; if (bus.ram_address !== 9'h0) $display("FAIL rst_ram_address got=%h exp=0", bus.ram_address); else n_pass++;
        n_chk++; if (bus.ram_in !== 16'h0) $display("FAIL rst_ram_in got=%h exp=0", bus.ram_in); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else n_pass++;
`ifdef RAM512_ARB_STATS_EN
        n_chk++; if (gc0 !== 16'h0) $display("FAIL rst_grant_cnt0 got=%0d exp=0", gc0); else n_pass++;
        n_chk++; if (gc1 !== 16'h0) $display("FAIL rst_grant_cnt1 got=%0d exp=0", gc1); else n_pass++;
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        last_served = 1;
    endtask

    task automatic test_write_read();
        logic [15:0] rd, exp;
        int ac, st;
        st = cyc;
        exp = ref_access(1'b1, 9'h000, 16'h0001);
        txn(0, 1'b1, 9'h000, 16'h0001, rd, ac);
        last_served = 0;
        n_chk++; if (ac - st !== 2) $display("FAIL wr_latency got=%0d exp=2", ac - st); else n_pass++;
        n_chk++; if (rd !== exp) $display("FAIL wr_old_data got=%h exp=%h", rd, exp); else n_pass++;
        st = cyc;
        exp = ref_access(1'b0, 9'h000, 16'h0);
        txn(0, 1'b0, 9'h000, 16'h0, rd, ac);
        n_chk++; if (ac - st !== 2) $display("FAIL rd_latency got=%0d exp=2", ac - st); else n_pass++;
        n_chk++; if (rd !== 16'h0001) $display("FAIL rd_data got=%h exp=0001", rd); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.ack0 !== 1'b0) $display("FAIL ack0_one_cycle got=%b exp=0", bus.ack0); else n_pass++;
        n_chk++; if (bus.rdata0 !== exp) $display("FAIL rdata0_hold got=%h exp=%h", bus.rdata0, exp); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        logic [15:0] r0, r1, e0, e1;
        logic [8:0] a0, a1;
        int c0, c1, st;
        do_reset();
        a0 = 9'($urandom);
        a1 = 9'($urandom);
        e0 = ref_access(1'b0, a0, 16'h0);
        e1 = ref_access(1'b0, a1, 16'h0);
        st = cyc;
        fork
            txn(0, 1'b0, a0, 16'h0, r0, c0);
            txn(1, 1'b0, a1, 16'h0, r1, c1);
        join
        last_served = 1;
        n_chk++; if (c0 - st !== 2) $display("FAIL sim_p0_first got=%0d exp=2", c0 - st); else n_pass++;
        n_chk++; if (c1 - c0 !== 3) $display("FAIL sim_p1_gap got=%0d exp=3", c1 - c0); else n_pass++;
        n_chk++; if (r0 !== e0) $display("FAIL sim_rdata0 got=%h exp=%h", r0, e0); else n_pass++;
        n_chk++; if (r1 !== e1) $display("FAIL sim_rdata1 got=%h exp=%h", r1, e1); else n_pass++;
    endtask

    task automatic test_contention();
        bit          we [2][3];
        logic [8:0]  a  [2][3];
        logic [15:0] d  [2][3];
        logic [15:0] rd [2][3];
        logic [15:0] ex [2][3];
        int          ac [2][3];
        int          q0;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 3; k++) begin
                we[p][k] = 1'($urandom);
                a[p][k]  = 9'($urandom_range(0, 3));
                d[p][k]  = 16'($urandom);
            end
        // both held: service alternates 0,1,0,1,0,1
        for (int j = 0; j < 6; j++)
            ex[j % 2][j / 2] = ref_access(we[j % 2][j / 2], a[j % 2][j / 2], d[j % 2][j / 2]);
        q0 = ack_q.size();
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    txn(0, we[0][k], a[0][k], d[0][k], rd[0][k], ac[0][k]);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    txn(1, we[1][k], a[1][k], d[1][k], rd[1][k], ac[1][k]);
                    @(posedge clk); #1;
                end
            end
        join
        last_served = 1;
        for (int j = 0; j < 6; j++) begin
            n_chk++;
            if (rd[j % 2][j / 2] !== ex[j % 2][j / 2])
                $display("FAIL cont_rdata txn=%0d got=%h exp=%h", j, rd[j % 2][j / 2], ex[j % 2][j / 2]);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (ac[1][k] - ac[0][k] !== 3) $display("FAIL cont_gap k=%0d got=%0d exp=3", k, ac[1][k] - ac[0][k]);
            else n_pass++;
        end
        n_chk++;
        if (ack_q.size() - q0 !== 6) $display("FAIL cont_ack_count got=%0d exp=6", ack_q.size() - q0);
        else begin
            n_pass++;
            for (int j = 0; j < 6; j++) begin
                n_chk++;
                if (ack_q[q0 + j] !== j % 2) $display("FAIL cont_order idx=%0d got=%0d exp=%0d", j, ack_q[q0 + j], j % 2);
                else n_pass++;
            end
        end
`ifdef RAM512_ARB_STATS_EN
        n_chk++; if (gc0 !== 16'd3) $display("FAIL stats_cnt0 got=%0d exp=3", gc0); else n_pass++;
        n_chk++; if (gc1 !== 16'd3) $display("FAIL stats_cnt1 got=%0d exp=3", gc1); else n_pass++;
        do_reset();
        @(negedge clk);
        n_chk++; if (gc0 !== 16'd0) $display("FAIL stats_clr0 got=%0d exp=0", gc0); else n_pass++;
        n_chk++; if (gc1 !== 16'd0) $display("FAIL stats_clr1 got=%0d exp=0", gc1); else n_pass++;
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_cross_port();
        logic [15:0] rd, exp;
        int ac;
        exp = ref_access(1'b1, 9'h002, 16'h1F01);
        txn(1, 1'b1, 9'h002, 16'h1F01, rd, ac);
        last_served = 1;
        n_chk++; if (rd !== exp) $display("FAIL cross_wr_old got=%h exp=%h", rd, exp); else n_pass++;
        exp = ref_access(1'b0, 9'h002, 16'h0);
        txn(0, 1'b0, 9'h002, 16'h0, rd, ac);
        last_served = 0;
        n_chk++; if (rd !== 16'h1F01) $display("FAIL cross_rd got=%h exp=1f01", rd); else n_pass++;
    endtask

    task automatic test_reset_access();
        logic [15:0] rd, exp;
        int ac, seen;
        exp = ref_access(1'b1, 9'h027, 16'h0000);
        txn(0, 1'b1, 9'h027, 16'h0000, rd, ac);
        last_served = 0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 9'h027; bus.wdata1 = 16'hFFFF;
        @(posedge clk); #1;
        // now in ACCESS for the port 1 write
        reset = 1'b1;
        #1;
        n_chk++; if (bus.ram_address !== 9'h027) $display("FAIL rsta_addr got=%h exp=027", bus.ram_address); else n_pass++;
        n_chk++; if (bus.ram_load !== 1'b0) $display("FAIL rsta_load got=%b exp=0", bus.ram_load); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req1 = 1'b0;
        last_served = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_chk++; if (bus.busy !== 1'b0) $display("FAIL rsta_idle got=%b exp=0", bus.busy); else n_pass++;
            end
            if (bus.ack1) seen++;
        end
        n_chk++; if (seen !== 0) $display("FAIL rsta_no_ack got=%0d exp=0", seen); else n_pass++;
        @(posedge clk); #1;
        exp = ref_access(1'b0, 9'h027, 16'h0);
        txn(0, 1'b0, 9'h027, 16'h0, rd, ac);
        last_served = 0;
        n_chk++; if (rd !== exp) $display("FAIL rsta_readback got=%h exp=%h", rd, exp); else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int          mode, st, first, second;
            bit          w [2];
            logic [8:0]  a [2];
            logic [15:0] d [2];
            logic [15:0] rd [2];
            logic [15:0] ex [2];
            int          ac [2];
            mode = $urandom_range(0, 2);
            for (int p = 0; p < 2; p++) begin
                w[p] = 1'($urandom);
                a[p] = 9'($urandom_range(0, 7));
                d[p] = 16'($urandom);
            end
            st = cyc;
            if (mode < 2) begin
                ex[mode] = ref_access(w[mode], a[mode], d[mode]);
                txn(mode, w[mode], a[mode], d[mode], rd[mode], ac[mode]);
                last_served = mode;
                n_chk++; if (ac[mode] - st !== 2) $display("FAIL rnd_latency r=%0d got=%0d exp=2", r, ac[mode] - st); else n_pass++;
                n_chk++; if (rd[mode] !== ex[mode]) $display("FAIL rnd_rdata r=%0d got=%h exp=%h", r, rd[mode], ex[mode]); else n_pass++;
            end else begin
                first  = 1 - last_served;
                second = last_served;
                ex[first]  = ref_access(w[first], a[first], d[first]);
                ex[second] = ref_access(w[second], a[second], d[second]);
                fork
                    txn(0, w[0], a[0], d[0], rd[0], ac[0]);
                    txn(1, w[1], a[1], d[1], rd[1], ac[1]);
                join
                last_served = second;
                n_chk++; if (ac[first] - st !== 2) $display("FAIL rnd_first r=%0d got=%0d exp=2", r, ac[first] - st); else n_pass++;
                n_chk++; if (ac[second] - ac[first] !== 3) $display("FAIL rnd_second r=%0d got=%0d exp=3", r, ac[second] - ac[first]); else n_pass++;
                n_chk++; if (rd[0] !== ex[0]) $display("FAIL rnd_rdata0 r=%0d got=%h exp=%h", r, rd[0], ex[0]); else n_pass++;
                n_chk++; if (rd[1] !== ex[1]) $display("FAIL rnd_rdata1 r=%0d got=%h exp=%h", r, rd[1], ex[1]); else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        preload_en = 1'b0;
        last_served = 1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 512; i++) begin
            init_ram[i] = 16'($urandom);
            mem_ref[i]  = init_ram[i];
        end
        test_reset();
        test_write_read();
        test_simultaneous();
        test_contention();
        test_cross_port();
        test_reset_access();
        test_random();
        n_chk++; if (both_ack_cnt !== 0) $display("FAIL both_acks got=%0d exp=0", both_ack_cnt); else n_pass++;
        n_chk++; if (stray_load_cnt !== 0) $display("FAIL load_outside_access got=%0d exp=0", stray_load_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
